enigma_msg_sched: RTL and testbench

//  Message-level scheduler sharing one enigma_top core between NUM_REQ requesters.

---
 rtl/enigma_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/enigma_msg_sched.sv | 163 ++++++++++++++++
 tb/tb_enigma_msg_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and defaults for the enigma message scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   sched_state_e : scheduler FSM states
//   core_sym_t    : one symbol beat on the core bus at the default width
package enigma_pkg;

  localparam int SYMB_W_DEF = 7;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ROT_RST,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

  typedef struct packed {
    logic                         vld;
    logic signed [SYMB_W_DEF-1:0] sym;
  } core_sym_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer.
// Latency: grant is combinational; the pointer moves on the cycle after upd_i.
// Backpressure: none, the caller decides when a grant is taken via upd_i.
//   clk_i, rst_i : clock, async active-low reset
//   req_i        : request vector
//   upd_i        : grant taken, pointer moves to winner+1
//   gnt_o        : one-hot winner, gnt_id_o its index, gnt_vld_o any winner
module rr_arbiter #(
  parameter int N = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            upd_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_vld_o
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset back to the pointer so the closest
  // requester at or after the pointer is the last (winning) assignment.
  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        gnt_vld_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr <= '0;
    end else if (upd_i && gnt_vld_o) begin
      ptr <= (gnt_id_o == ID_W'(N - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/enigma_msg_sched.sv
// Shares one enigma core between NUM_REQ requesters, one whole message at a time.
// Latency: symbol in -> core 1 cycle; core return -> out_* 1 cycle; grant 2 cycles after req.
// Backpressure: sym_rdy_o only in STREAM; core returns are never stalled, extras dropped.
//   req_i/req_len_i        : message request and length per requester
//   grant_o, done_o        : one-hot owner and completion pulse
//   sym_val_i/sym_i/sym_rdy_o : symbol handshake from the granted requester
//   core_*_o / core_*_i    : enigma_top drive and return buses
//   out_*                  : tagged returned symbols; err_timeout_o drain abort pulse
module enigma_msg_sched
  import enigma_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SYMB_W        = SYMB_W_DEF,
  parameter int LEN_W         = LEN_W_DEF,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]        grant_o,
  input  logic [NUM_REQ-1:0]        sym_val_i,
  input  logic [NUM_REQ*SYMB_W-1:0] sym_i,
  output logic                      sym_rdy_o,
  output logic                      core_rotors_rst_o,
  output logic [LEN_W-1:0]          core_symb_numb_o,
  output logic                      core_symb_val_o,
  output logic [SYMB_W-1:0]         core_symbol_o,
  input  logic                      core_symb_val_i,
  input  logic [SYMB_W-1:0]         core_symbol_i,
  output logic                      out_val_o,
  output logic [SYMB_W-1:0]         out_symbol_o,
  output logic [ID_W-1:0]           out_id_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_timeout_o
);

  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DRAIN_TIMEOUT);
  localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);

  sched_state_e      state;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  sent_cnt;
  logic [LEN_W-1:0]  rcv_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              aborted;

  logic [NUM_REQ-1:0] arb_oh;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic               xfer;
  logic               ret_ok;
  logic [SYMB_W-1:0]  cur_sym;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .upd_i     (state == ST_ARB),
    .gnt_o     (arb_oh),
    .gnt_id_o  (arb_id),
    .gnt_vld_o (arb_any)
  );

  assign cur_sym = sym_i[id_q*SYMB_W +: SYMB_W];
  assign xfer    = sym_rdy_o & sym_val_i[id_q];
  // Returns are only owned by the current message and only up to its length.
  assign ret_ok  = core_symb_val_i & ((state == ST_STREAM) | (state == ST_DRAIN))
                 & (rcv_cnt != core_symb_numb_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state             <= ST_IDLE;
      id_q              <= '0;
      sent_cnt          <= '0;
      rcv_cnt           <= '0;
      idle_cnt          <= '0;
      aborted           <= 1'b0;
      grant_o           <= '0;
      sym_rdy_o         <= 1'b0;
      core_rotors_rst_o <= 1'b0;
      core_symb_numb_o  <= '0;
      core_symb_val_o   <= 1'b0;
      core_symbol_o     <= '0;
      out_val_o         <= 1'b0;
      out_symbol_o      <= '0;
      out_id_o          <= '0;
      done_o            <= '0;
      err_timeout_o     <= 1'b0;
    end else begin
      core_rotors_rst_o <= 1'b0;
      done_o            <= '0;
      err_timeout_o     <= 1'b0;
      core_symb_val_o   <= xfer;
      core_symbol_o     <= xfer ? cur_sym : '0;
      out_val_o         <= ret_ok;
      out_symbol_o      <= ret_ok ? core_symbol_i : '0;
      out_id_o          <= ret_ok ? id_q : '0;
      if (ret_ok) rcv_cnt <= rcv_cnt + ONE;

      case (state)
        ST_IDLE: begin
          if (|req_i) state <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_any) begin
            id_q              <= arb_id;
            core_symb_numb_o  <= req_len_i[arb_id*LEN_W +: LEN_W];
            grant_o           <= arb_oh;
            core_rotors_rst_o <= 1'b1;
            sent_cnt          <= '0;
            rcv_cnt           <= '0;
            idle_cnt          <= '0;
            aborted           <= 1'b0;
            state             <= ST_ROT_RST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ROT_RST: begin
          if (core_symb_numb_o == '0) begin
            state <= ST_DONE;
          end else begin
            sym_rdy_o <= 1'b1;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            sent_cnt <= sent_cnt + ONE;
            if ((sent_cnt + ONE) == core_symb_numb_o) begin
              sym_rdy_o <= 1'b0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rcv_cnt == core_symb_numb_o) begin
            state <= ST_DONE;
          end else if (core_symb_val_i) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_MAX) begin
            err_timeout_o <= 1'b1;
            aborted       <= 1'b1;
            state         <= ST_DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // grant_o still holds the owner here, so it doubles as the done mask.
          if (!aborted) done_o <= grant_o;
          grant_o <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_msg_sched.sv
module tb_enigma_msg_sched;

  localparam int NR = 2;
  localparam int SW = 7;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i;
  logic [NR*LW-1:0] req_len_i;
  logic [NR-1:0]   grant_o;
  logic [NR-1:0]   sym_val_i;
  logic [NR*SW-1:0] sym_i;
  logic            sym_rdy_o;
  logic            core_rotors_rst_o;
  logic [LW-1:0]   core_symb_numb_o;
  logic            core_symb_val_o;
  logic [SW-1:0]   core_symbol_o;
  logic            core_symb_val_i;
  logic [SW-1:0]   core_symbol_i;
  logic            out_val_o;
  logic [SW-1:0]   out_symbol_o;
  logic            out_id_o;
  logic [NR-1:0]   done_o;
  logic            err_timeout_o;
  logic [31:0]     all_outs;

  always #5 clk = ~clk;

  enigma_msg_sched #(.NUM_REQ(NR), .SYMB_W(SW), .LEN_W(LW), .DRAIN_TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_len_i(req_len_i), .grant_o(grant_o),
    .sym_val_i(sym_val_i), .sym_i(sym_i), .sym_rdy_o(sym_rdy_o),
    .core_rotors_rst_o(core_rotors_rst_o), .core_symb_numb_o(core_symb_numb_o),
    .core_symb_val_o(core_symb_val_o), .core_symbol_o(core_symbol_o),
    .core_symb_val_i(core_symb_val_i), .core_symbol_i(core_symbol_i),
    .out_val_o(out_val_o), .out_symbol_o(out_symbol_o), .out_id_o(out_id_o),
    .done_o(done_o), .err_timeout_o(err_timeout_o)
  );

  assign all_outs = {grant_o, sym_rdy_o, core_rotors_rst_o, core_symb_numb_o, core_symb_val_o,
                     core_symbol_o, out_val_o, out_symbol_o, out_id_o, done_o, err_timeout_o};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int rot_cycles, core_b2b, done_cnt0, done_cnt1, err_cnt, overlap;
  int last_core_cyc, err_cyc, grant_cyc, done_cyc;
  int echo_limit = 1000;
  int echoed;
  bit prev_cv;
  logic [NR-1:0] prev_grant;
  logic signed [SW-1:0] core_log[$];
  logic signed [SW-1:0] out_log[$];
  logic id_log[$];
  int grant_order[$];
  logic signed [SW-1:0] msg_syms[0:127];

  task automatic clear_logs();
    rot_cycles = 0; core_b2b = 0; done_cnt0 = 0; done_cnt1 = 0; err_cnt = 0; overlap = 0;
    last_core_cyc = 0; err_cyc = 0; grant_cyc = 0; done_cyc = 0; echoed = 0;
    core_log.delete(); out_log.delete(); id_log.delete(); grant_order.delete();
  endtask

  // Core model (zero-latency echo seen at the next rising edge) plus monitor.
  initial begin
    core_symb_val_i = 1'b0;
    core_symbol_i   = '0;
    prev_cv = 1'b0;
    prev_grant = '0;
    clear_logs();
    forever begin
      @(negedge clk);
      cyc++;
      if (core_rotors_rst_o) rot_cycles++;
      if (core_symb_val_o) begin
        core_log.push_back(core_symbol_o);
        if (prev_cv) core_b2b++;
        last_core_cyc = cyc;
      end
      prev_cv = core_symb_val_o;
      if (out_val_o) begin
        out_log.push_back(out_symbol_o);
        id_log.push_back(out_id_o);
      end
      if (done_o[0]) begin done_cnt0++; done_cyc = cyc; end
      if (done_o[1]) begin done_cnt1++; done_cyc = cyc; end
      if (err_timeout_o) begin err_cnt++; err_cyc = cyc; end
      if (grant_o != '0 && prev_grant == '0) begin
        grant_order.push_back(grant_o[1] ? 1 : 0);
        grant_cyc = cyc;
      end
      if ($countones(grant_o) > 1) overlap++;
      prev_grant = grant_o;
      if (core_symb_val_o && echoed < echo_limit) begin
        core_symb_val_i = 1'b1;
        core_symbol_i   = core_symbol_o;
        echoed++;
      end else begin
        core_symb_val_i = 1'b0;
        core_symbol_i   = '0;
      end
    end
  end

  task automatic do_reset(input logic [NR-1:0] req_at_release);
    rst_i = 1'b0; req_i = '0; sym_val_i = '0; sym_i = '0;
    repeat (3) @(negedge clk);
    clear_logs();
    req_i = req_at_release;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic send_msg(input int r, input int len, input bit gaps, input int wait_cycles,
                          output bit finished);
    int idx, guard;
    bit rdy, v, tog;
    req_len_i[r*LW +: LW] = LW'(len);
    req_i[r] = 1'b1;
    guard = 0;
    while (!grant_o[r] && guard < 50) begin @(negedge clk); guard++; end
    req_i[r] = 1'b0;
    idx = 0; guard = 0; tog = 1'b1;
    while (idx < len && guard < 1000) begin
      rdy = sym_rdy_o;
      v = gaps ? tog : 1'b1;
      sym_val_i[r] = v;
      sym_i[r*SW +: SW] = msg_syms[idx];
      @(posedge clk);
      if (rdy && v) idx++;
      tog = ~tog; guard++;
      #1;
    end
    sym_val_i[r] = 1'b0;
    guard = 0;
    while (!(done_o[r] || err_timeout_o) && guard < wait_cycles) begin @(negedge clk); guard++; end
    finished = done_o[r] || err_timeout_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = '0; req_len_i = '0; sym_val_i = '0; sym_i = '0;
    #2;
    n_checks++;
    if (all_outs !== 32'h0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs !== 32'h0) begin n_fail++; $display("FAIL idle_outs got=%h exp=0", all_outs); end
  endtask

  task automatic test_basic();
    logic signed [SW-1:0] exp[3];
    bit fin;
    exp[0] = 7'sd5; exp[1] = -7'sd2; exp[2] = 7'sd7;
    do_reset('0);
    for (int i = 0; i < 3; i++) msg_syms[i] = exp[i];
    send_msg(0, 3, 1'b0, 100, fin);
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL basic_finish got=0 exp=1"); end
    n_checks++;
    if (rot_cycles != 1) begin n_fail++; $display("FAIL basic_rot got=%0d exp=1", rot_cycles); end
    n_checks++;
    if (core_symb_numb_o !== 8'd3) begin n_fail++; $display("FAIL basic_numb got=%0d exp=3", core_symb_numb_o); end
    n_checks++;
    if (core_log.size() != 3 || out_log.size() != 3) begin
      n_fail++; $display("FAIL basic_counts core=%0d out=%0d exp=3", core_log.size(), out_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (core_log[i] !== exp[i] || out_log[i] !== exp[i] || id_log[i] !== 1'b0) begin
          n_fail++; $display("FAIL basic_sym%0d core=%0d out=%0d id=%0d exp=%0d id 0",
                             i, core_log[i], out_log[i], id_log[i], exp[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt0 != 1 || done_cnt1 != 0 || err_cnt != 0) begin
      n_fail++; $display("FAIL basic_done d0=%0d d1=%0d err=%0d exp 1/0/0", done_cnt0, done_cnt1, err_cnt);
    end
  endtask

  task automatic test_round_robin();
    int guard;
    req_len_i = {8'd1, 8'd1};
    do_reset(2'b11);
    sym_i = {-7'sd20, 7'sd10};
    sym_val_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (grant_order.size() <= k && guard < 100) begin @(negedge clk); guard++; end
      if (k == 3) req_i = '0;
    end
    guard = 0;
    while (done_cnt0 + done_cnt1 < 4 && guard < 100) begin @(negedge clk); guard++; end
    sym_val_i = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (grant_order.size() != 4 || core_log.size() != 4 || id_log.size() != 4) begin
      n_fail++; $display("FAIL rr_counts grants=%0d core=%0d out=%0d exp=4",
                         grant_order.size(), core_log.size(), id_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (grant_order[k] != k % 2 || id_log[k] !== 1'(k % 2) ||
            core_log[k] !== ((k % 2 == 0) ? 7'sd10 : -7'sd20)) begin
          n_fail++; $display("FAIL rr_msg%0d grant=%0d id=%0d sym=%0d exp owner %0d",
                             k, grant_order[k], id_log[k], core_log[k], k % 2);
        end
      end
    end
    n_checks++;
    if (rot_cycles != 4 || overlap != 0) begin
      n_fail++; $display("FAIL rr_rot_overlap rot=%0d overlap=%0d exp 4/0", rot_cycles, overlap);
    end
    n_checks++;
    if (done_cnt0 != 2 || done_cnt1 != 2) begin
      n_fail++; $display("FAIL rr_done d0=%0d d1=%0d exp 2/2", done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_timeout();
    bit fin;
    do_reset('0);
    echo_limit = 2;
    msg_syms[0] = 7'sd1; msg_syms[1] = 7'sd2; msg_syms[2] = 7'sd3;
    send_msg(0, 3, 1'b0, 300, fin);
    repeat (3) @(negedge clk);
    echo_limit = 1000;
    n_checks++;
    if (!fin || err_cnt != 1) begin n_fail++; $display("FAIL to_err fin=%0d err=%0d exp 1/1", fin, err_cnt); end
    n_checks++;
    if (done_cnt0 != 0 || out_log.size() != 2) begin
      n_fail++; $display("FAIL to_nodone done=%0d out=%0d exp 0/2", done_cnt0, out_log.size());
    end
    n_checks++;
    if (err_cyc - last_core_cyc < 64 || err_cyc - last_core_cyc > 66) begin
      n_fail++; $display("FAIL to_delay got=%0d exp 64..66", err_cyc - last_core_cyc);
    end
    n_checks++;
    if (grant_o !== 2'b00) begin n_fail++; $display("FAIL to_grant got=%b exp=00", grant_o); end
  endtask

  task automatic test_zero_len();
    bit fin;
    clear_logs();
    send_msg(1, 0, 1'b0, 20, fin);
    repeat (2) @(negedge clk);
    n_checks++;
    if (!fin || done_cnt1 != 1 || done_cyc - grant_cyc != 2) begin
      n_fail++; $display("FAIL zl_done fin=%0d cnt=%0d delay=%0d exp 1/1/2", fin, done_cnt1, done_cyc - grant_cyc);
    end
    n_checks++;
    if (rot_cycles != 1 || core_log.size() != 0) begin
      n_fail++; $display("FAIL zl_core rot=%0d syms=%0d exp 1/0", rot_cycles, core_log.size());
    end
  endtask

  task automatic test_gaps();
    bit fin;
    int bad;
    do_reset('0);
    for (int i = 0; i < 100; i++) msg_syms[i] = SW'(i - 50);
    send_msg(0, 100, 1'b1, 100, fin);
    n_checks++;
    if (!fin || core_log.size() != 100 || out_log.size() != 100) begin
      n_fail++; $display("FAIL gap_counts fin=%0d core=%0d out=%0d exp 100", fin, core_log.size(), out_log.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 100; i++) if (core_log[i] !== msg_syms[i] || out_log[i] !== msg_syms[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL gap_order bad=%0d exp=0", bad); end
    end
    n_checks++;
    if (core_b2b != 0) begin n_fail++; $display("FAIL gap_b2b got=%0d exp=0", core_b2b); end
  endtask

  task automatic test_reset_mid();
    bit fin;
    int guard;
    do_reset('0);
    req_len_i[LW-1:0] = 8'd50;
    req_i[0] = 1'b1;
    guard = 0;
    while (!grant_o[0] && guard < 50) begin @(negedge clk); guard++; end
    req_i[0] = 1'b0;
    sym_val_i[0] = 1'b1; sym_i[SW-1:0] = 7'sd3;
    repeat (8) @(posedge clk);
    n_checks++;
    if (grant_o !== 2'b01 || sym_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_stream grant=%b rdy=%b exp 01/1", grant_o, sym_rdy_o);
    end
    #3 rst_i = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== 32'h0) begin n_fail++; $display("FAIL mid_async got=%h exp=0", all_outs); end
    sym_val_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt0 != 0 || err_cnt != 0) begin
      n_fail++; $display("FAIL mid_pulses done=%0d err=%0d exp 0/0", done_cnt0, err_cnt);
    end
    clear_logs();
    msg_syms[0] = 7'sd9; msg_syms[1] = -7'sd9;
    send_msg(0, 2, 1'b0, 50, fin);
    n_checks++;
    if (!fin || done_cnt0 != 1 || core_log.size() != 2) begin
      n_fail++; $display("FAIL mid_after fin=%0d done=%0d syms=%0d exp 1/1/2", fin, done_cnt0, core_log.size());
    end else begin
      n_checks++;
      if (core_log[0] !== 7'sd9 || core_log[1] !== -7'sd9) begin
        n_fail++; $display("FAIL mid_syms got=%0d,%0d exp=9,-9", core_log[0], core_log[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
